// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong game-level controller.
//   state_e            : game FSM state (IDLE=0, NEWBALL=1, PLAY=2, OVER=3)
//   SCORE_W / BALL_W   : widths of the score and balls-remaining outputs
//   LFSR_TAPS          : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   LFSR_SEED_DEFAULT  : default LFSR reset / zero-recovery value
//   sat_inc / sat_dec  : saturating +1 / -1 helpers for score and ball
// -----------------------------------------------------------------------------
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      NEWBALL = 2'd1,
      PLAY    = 2'd2,
      OVER    = 2'd3
   } state_e;

   localparam int          SCORE_W           = 4;
   localparam int          BALL_W            = 2;
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // Score increment that sticks at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
   endfunction

   // Ball decrement that sticks at zero instead of wrapping.
   function automatic logic [BALL_W-1:0] sat_dec(input logic [BALL_W-1:0] v);
      return (v == {BALL_W{1'b0}}) ? v : v - BALL_W'(1);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_chk.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl_chk
// Simulation checker for pong_game_ctrl: parameter legality and the
// play_active / state relationship.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset of the controller
//   state       : controller state output
//   play_active : controller motion-enable output
// -----------------------------------------------------------------------------
module pong_game_ctrl_chk
   import pong_pkg::*;
#(
   parameter int unsigned BALLS_INIT      = 3,
   parameter int unsigned SERVE_DELAY_CYC = 1,
   parameter int unsigned DEBOUNCE_CYC    = 1
)(
   input logic       clk,
   input logic       rst,
   input logic [1:0] state,
   input logic       play_active
);

   // Parameter ranges and output consistency, sampled each cycle out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_balls_init : assert (BALLS_INIT >= 32'd1 && BALLS_INIT <= 32'd3);
         a_serve_cyc  : assert (SERVE_DELAY_CYC >= 32'd1);
         a_db_cyc     : assert (DEBOUNCE_CYC >= 32'd1);
         a_play_state : assert (play_active == (state == PLAY));
      end
   end

endmodule

// File: rtl/pong_lfsr16.sv
// -----------------------------------------------------------------------------
// pong_lfsr16
// 16-bit Fibonacci LFSR, shifting left every cycle with the XOR of the tapped
// bits fed into bit 0. An all-zero register (lock-up state) reloads the seed
// on the next cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset (loads seed)
//   seed : reset / recovery value (expected to be a constant)
//   rng  : current register contents
// -----------------------------------------------------------------------------
module pong_lfsr16
   import pong_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] rng
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Next LFSR value, with lock-up recovery.
   always_comb begin
      lfsr_d = lfsr_q;
      if (lfsr_q == 16'd0) begin
         lfsr_d = seed;
      end else begin
         lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rng = lfsr_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game-level controller for the single-player pong playfield. Sequences the
// serve delay (NEWBALL), play (PLAY) and game-over (OVER), keeps score and
// balls remaining, and supplies a free-running pseudo-random word.
//
// Optional macro PONG_BTN_SYNC_EN: when defined, btn_start is passed through
// a 2-flop synchronizer and a DEBOUNCE_CYC debouncer before edge detection.
// When undefined, btn_start is assumed synchronous and clean.
//
// Ports:
//   clk         in   pixel clock (25 MHz)
//   rst         in   asynchronous, active-high reset
//   btn_start   in   start / restart button
//   hit         in   paddle hit indication from the playfield
//   miss        in   ball-lost indication from the playfield
//   over        in   game-over indication from the playfield
//   score       out  current score (saturating, 4 bits)
//   ball        out  balls remaining
//   rng         out  16-bit pseudo-random word
//   play_active out  high only in PLAY; enables playfield motion
//   state       out  FSM state for the text overlay
//   win         out  high in OVER when score >= WIN_SCORE
// -----------------------------------------------------------------------------
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned SERVE_DELAY_CYC = 50_000_000,
   parameter int unsigned WIN_SCORE       = 12,
   parameter int unsigned BALLS_INIT      = 3,
   parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT,
   parameter int unsigned DEBOUNCE_CYC    = 250_000
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               hit,
   input  logic               miss,
   input  logic               over,
   output logic [SCORE_W-1:0] score,
   output logic [BALL_W-1:0]  ball,
   output logic [15:0]        rng,
   output logic               play_active,
   output logic [1:0]         state,
   output logic               win
);

   localparam int                unsigned TMR_W = $clog2(SERVE_DELAY_CYC + 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD       = TMR_W'(SERVE_DELAY_CYC - 1);
   localparam logic [BALL_W-1:0] BALL_LOAD      = BALL_W'(BALLS_INIT);

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [BALL_W-1:0]  ball_q,  ball_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               play_active_q, win_q;
   logic               hit_q, miss_q, start_q;
   logic               start_lvl_s;
   logic               hit_e, miss_e, start_e;
   logic               win_now_s;

`ifdef PONG_BTN_SYNC_EN
   localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

   logic            sync1_q, sync2_q, db_q;
   logic [DB_W-1:0] db_cnt_q;

   // Button synchronizer and debouncer: the debounced level follows the
   // synchronized input only once it has differed for DEBOUNCE_CYC cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q <= btn_start;
         sync2_q <= sync1_q;
         if (sync2_q == db_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            db_q     <= sync2_q;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
         end
      end
   end

   assign start_lvl_s = db_q;
`else
   assign start_lvl_s = btn_start;
`endif

   // Rising edges: a level held high produces a single event.
   assign hit_e   = hit         & ~hit_q;
   assign miss_e  = miss        & ~miss_q;
   assign start_e = start_lvl_s & ~start_q;

   // Game FSM next state, score, ball and serve timer.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      ball_d  = ball_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (start_e) begin
               score_d = '0;
               ball_d  = BALL_LOAD;
               timer_d = TMR_LOAD;
               state_d = NEWBALL;
            end else begin
               state_d = IDLE;
            end
         end
         NEWBALL: begin
            // hit/miss are deliberately ignored while the serve timer runs
            if (timer_q == '0) begin
               state_d = PLAY;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         PLAY: begin
            if (miss_e) begin
               // a miss wins over a simultaneous hit; the hit is dropped
               ball_d = sat_dec(ball_q);
               if (ball_d == '0) begin
                  state_d = OVER;
               end else begin
                  timer_d = TMR_LOAD;
                  state_d = NEWBALL;
               end
            end else if (hit_e) begin
               score_d = sat_inc(score_q);
               if (({{(32-SCORE_W){1'b0}}, score_d} >= WIN_SCORE) || over) begin
                  state_d = OVER;
               end else begin
                  state_d = PLAY;
               end
            end else if (over) begin
               state_d = OVER;
            end else begin
               state_d = PLAY;
            end
         end
         OVER: begin
            if (start_e) begin
               score_d = '0;
               ball_d  = BALL_LOAD;
               timer_d = TMR_LOAD;
               state_d = NEWBALL;
            end else begin
               state_d = OVER;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign win_now_s = (state_d == OVER) &&
                      ({{(32-SCORE_W){1'b0}}, score_d} >= WIN_SCORE);

   // State, counters, edge-detect history and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         score_q       <= '0;
         ball_q        <= BALL_LOAD;
         timer_q       <= '0;
         play_active_q <= 1'b0;
         win_q         <= 1'b0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         start_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         ball_q        <= ball_d;
         timer_q       <= timer_d;
         play_active_q <= (state_d == PLAY);
         win_q         <= win_now_s;
         hit_q         <= hit;
         miss_q        <= miss;
         start_q       <= start_lvl_s;
      end
   end

   pong_lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .rng  (rng)
   );

   pong_game_ctrl_chk #(
      .BALLS_INIT      (BALLS_INIT),
      .SERVE_DELAY_CYC (SERVE_DELAY_CYC),
      .DEBOUNCE_CYC    (DEBOUNCE_CYC)
   ) u_chk (
      .clk         (clk),
      .rst         (rst),
      .state       (state_q),
      .play_active (play_active_q)
   );

   assign score       = score_q;
   assign ball        = ball_q;
   assign state       = state_q;
   assign play_active = play_active_q;
   assign win         = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed bench for pong_game_ctrl (SERVE_DELAY_CYC=4, button feature off).
// A cycle-level game model predicts every output; a negedge process compares
// the DUT to it, and directed steps pin key values with literal expectations.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

   logic        clk;
   logic        rst;
   logic        btn_start, hit, miss, over;
   logic [3:0]  score;
   logic [1:0]  ball;
   logic [15:0] rng;
   logic        play_active;
   logic [1:0]  state;
   logic        win;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   pong_game_ctrl #(.SERVE_DELAY_CYC(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_start   (btn_start),
      .hit         (hit),
      .miss        (miss),
      .over        (over),
      .score       (score),
      .ball        (ball),
      .rng         (rng),
      .play_active (play_active),
      .state       (state),
      .win         (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural game model ----------------
   // States as plain numbers: 0 idle, 1 serving, 2 playing, 3 game over.
   int          m_state, m_score, m_ball, m_serve;
   logic [15:0] m_lfsr;
   logic        hp, mp, sp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 0; m_score <= 0; m_ball <= 3; m_serve <= 0;
         m_lfsr  <= 16'hACE1;
         hp <= 1'b0; mp <= 1'b0; sp <= 1'b0;
      end else begin
         hp <= hit; mp <= miss; sp <= btn_start;
         if (m_lfsr == 16'd0) m_lfsr <= 16'hACE1;
         else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         case (m_state)
            0, 3: if (btn_start && !sp) begin
               m_score <= 0; m_ball <= 3; m_state <= 1; m_serve <= 4;
            end
            1: begin
               // serve lasts exactly 4 cycles counted from entry
               m_serve <= m_serve - 1;
               if (m_serve == 1) m_state <= 2;
            end
            2: begin
               if (miss && !mp) begin
                  m_ball  <= (m_ball == 0) ? 0 : m_ball - 1;
                  m_state <= (m_ball <= 1) ? 3 : 1;
                  m_serve <= 4;
               end else begin
                  if (hit && !hp) begin
                     m_score <= (m_score == 15) ? 15 : m_score + 1;
                     if (m_score + 1 >= 12) m_state <= 3;
                  end
                  if (over) m_state <= 3;
               end
            end
            default: m_state <= 0;
         endcase
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state",       int'(state),       m_state);
         chk("score",       int'(score),       m_score);
         chk("ball",        int'(ball),        m_ball);
         chk("rng",         int'(rng),         int'(m_lfsr));
         chk("play_active", int'(play_active), (m_state == 2) ? 1 : 0);
         chk("win",         int'(win),         (m_state == 3 && m_score >= 12) ? 1 : 0);
         chk("rng_nonzero", (rng != 16'd0) ? 1 : 0, 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_hit();
      hit = 1'b1; tick(1); hit = 1'b0;
   endtask

   task automatic pulse_miss();
      miss = 1'b1; tick(1); miss = 1'b0;
   endtask

   task automatic pulse_start();
      btn_start = 1'b1; tick(1); btn_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; btn_start = 1'b0; hit = 1'b0; miss = 1'b0; over = 1'b0;
      tick(2);
      rst = 1'b0;
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_ball",  int'(ball),  3);
      chk("rst_play",  int'(play_active), 0);
      chk("rst_win",   int'(win), 0);
      chk("rst_rng",   int'(rng), 16'hACE1);
      chk_en = 1'b1;
      tick(1);
      chk("rng_step1", int'(rng), 16'h59C3);
      tick(1);
      chk("rng_step2", int'(rng), 16'hB387);
      tick(8);
      chk("idle_state", int'(state), 0);
      chk("idle_rng_moved", (rng != 16'hACE1) ? 1 : 0, 1);

      // start and serve timing
      pulse_start();
      chk("start_state", int'(state), 1);
      tick(3);
      chk("serve_play_lo", int'(play_active), 0);
      tick(1);
      chk("serve_play_hi", int'(play_active), 1);

      // twelve separate hits end the game as a win
      for (int i = 0; i < 12; i++) begin
         pulse_hit();
         tick(1);
      end
      chk("win_score", int'(score), 12);
      chk("win_state", int'(state), 3);
      chk("win_flag",  int'(win), 1);

      // restart from OVER
      pulse_start();
      chk("restart_score", int'(score), 0);
      chk("restart_ball",  int'(ball), 3);
      chk("restart_state", int'(state), 1);
      tick(4);

      // held hit counts once
      hit = 1'b1; tick(20); hit = 1'b0; tick(1);
      chk("held_hit_score", int'(score), 1);

      // lives
      pulse_miss();
      chk("miss1_ball", int'(ball), 2);
      chk("miss1_state", int'(state), 1);
      tick(4);
      pulse_miss();
      chk("miss2_ball", int'(ball), 1);
      chk("miss2_state", int'(state), 1);
      tick(4);
      pulse_miss();
      chk("miss3_ball", int'(ball), 0);
      chk("miss3_state", int'(state), 3);
      chk("miss3_win", int'(win), 0);
      tick(2);

      // simultaneous hit and miss at score 5, ball 2
      pulse_start();
      tick(4);
      for (int i = 0; i < 5; i++) begin
         pulse_hit();
         tick(1);
      end
      pulse_miss();
      tick(4);
      hit = 1'b1; miss = 1'b1; tick(1); hit = 1'b0; miss = 1'b0;
      chk("simul_score", int'(score), 5);
      chk("simul_ball",  int'(ball), 1);
      chk("simul_state", int'(state), 1);
      tick(4);

      // reset mid-PLAY at score 7
      pulse_hit(); tick(1);
      pulse_hit(); tick(1);
      chk("pre_rst_score", int'(score), 7);
      #2 rst = 1'b1;
      #1;
      chk("midrst_score", int'(score), 0);
      chk("midrst_ball",  int'(ball), 3);
      chk("midrst_state", int'(state), 0);
      chk("midrst_play",  int'(play_active), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick(2);

      // over input, with a start press on the same cycle being ignored
      pulse_start();
      tick(4);
      over = 1'b1; btn_start = 1'b1; tick(1); over = 1'b0;
      chk("over_state", int'(state), 3);
      chk("over_score", int'(score), 0);
      tick(2);
      chk("over_hold_state", int'(state), 3);
      btn_start = 1'b0;
      tick(2);
      pulse_start();
      chk("over_restart_state", int'(state), 1);
      tick(6);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-level controller placed downstream of the single-player playfield renderer.
- Consumes its hit, miss and over indications; produces the score[3:0], ball[1:0] and rng[15:0] inputs the playfield reads.
- Sequences new-ball serve delay, play and game-over; gates playfield motion via play_active.
- Runs on the 25 MHz pixel clock.

Parameters:
- SERVE_DELAY_CYC, 50_000_000: cycles spent in NEWBALL before play resumes (2 s at 25 MHz).
- WIN_SCORE, 12: score at which the game ends as a win.
- BALLS_INIT, 3: balls at game start (1..3).
- LFSR_SEED, 16'hACE1: LFSR reset and recovery value.
- DEBOUNCE_CYC, 250_000: button debounce window; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  start/restart button
- hit  in  1  paddle hit indication from playfield
- miss  in  1  ball-lost indication from playfield
- over  in  1  game-over indication from playfield
- score  out  4  current score
- ball  out  2  balls remaining
- rng  out  16  pseudo-random word
- play_active  out  1  high only in PLAY; enables playfield motion
- state  out  2  FSM state, for text overlay
- win  out  1  high in OVER when score >= WIN_SCORE

Behaviour:
- Reset values: state=IDLE, score=0, ball=BALLS_INIT, rng=LFSR_SEED, play_active=0, win=0.
- Clock and reset: rst is asynchronous, active-high; clk is the clock. Reset mid-game aborts immediately to the reset values.
- State encoding: IDLE=0, NEWBALL=1, PLAY=2, OVER=3.
- Edge detection:
  - hit_q, miss_q and start_q are registered copies of their inputs.
  - hit_e = hit & ~hit_q; miss_e and start_e are formed the same way.
  - Counters update on the same clock edge as the detected edge, so results are visible 1 cycle after the input first goes high.
  - A level held high counts once.
- IDLE:
  - start_e loads score=0 and ball=BALLS_INIT, then goes to NEWBALL.
- NEWBALL:
  - On entry, the timer loads SERVE_DELAY_CYC-1; it decrements each cycle.
  - At timer==0, go to PLAY. play_active=0 throughout.
  - hit and miss are ignored.
- PLAY:
  - play_active=1.
  - miss_e has priority. It decrements ball (saturating at 0), discards any simultaneous hit_e, and goes to OVER if the new ball==0, else NEWBALL.
  - Otherwise hit_e increments score (saturating at 15). If the new score >= WIN_SCORE, go to OVER.
  - over high with no miss_e goes to OVER, with score and ball unchanged.
- OVER:
  - score and ball are held; win = (score >= WIN_SCORE).
  - start_e clears score, reloads ball and goes to NEWBALL.
  - start_e arriving on the transition cycle into OVER is ignored.
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1; shifts left every cycle with feedback into bit 0.
  - If the register ever reads 0, reload LFSR_SEED next cycle.
  - rng is the register output directly.
- Widths:
  - score arithmetic is 4-bit, saturating.
  - ball is 2-bit; BALLS_INIT > 3 is illegal (assertion in simulation).
  - Timer width is $clog2(SERVE_DELAY_CYC+1).

Optional Feature:
- Macro: PONG_BTN_SYNC_EN.
- Defined:
  - btn_start passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer changes its output only after the synchronized input has been stable for DEBOUNCE_CYC consecutive cycles.
  - start_e is derived from the debounced level.
  - Press-to-start_e latency is 2+DEBOUNCE_CYC+1 cycles.
- Undefined:
  - btn_start is treated as synchronous and clean; start_e latency is 1 cycle.
  - DEBOUNCE_CYC is unused.

Decomposition:
- Package pong_pkg holds:
  - state enum (IDLE, NEWBALL, PLAY, OVER);
  - SCORE_W=4 and BALL_W=2;
  - LFSR taps mask 16'hB400 and LFSR_SEED default.
- One sub-module, pong_lfsr16 (clk, rst, seed, rng), instantiated once.
- Synchronizer/debounce logic stays inline under the macro.

Test Plan:
- Bench override: SERVE_DELAY_CYC=4, macro undefined.
- Reset then idle: 10 cycles with no button -> state=0, score=0, ball=3, play_active=0, rng leaves 16'hACE1 and never reads 0.
- Start and serve: start pulse -> state=1 next cycle; play_active=1 exactly 4 cycles later.
- Scoring with saturation: 12 separate hit pulses in PLAY -> score=12, state=3, win=1. A hit held high 20 cycles -> score +1 only.
- Lives: 3 miss pulses with serve waits between them -> ball 2, 1, 0; states go NEWBALL, NEWBALL, OVER; win=0.
- Simultaneous events: hit and miss rise on the same cycle with score=5, ball=2 -> score=5, ball=1, state=NEWBALL.
- Reset mid-PLAY and restart from OVER: rst in PLAY at score=7 -> immediately score=0, ball=3, state=IDLE. In OVER, a start pulse -> score=0, ball=3, state=NEWBALL.
